// File: rtl/ped_signal_sequencer.sv
// Pedestrian walk sequencer: rotates the crossing, counts the walk down on Tick_1Hz, inserts a light-out gap.
// Latency: all outputs are registered and update on the CLK edge that samples Tick_1Hz=1.
// Backpressure: none. Tick_1Hz is a plain enable. Optional crossing skipping: PED_SKIP_EN.
module ped_signal_sequencer #(
    parameter int GREEN_TIME = 20,
    parameter int OUT_TIME   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tick_1Hz,
    input  logic       Enable,
`ifdef PED_SKIP_EN
    input  logic [3:0] Skip_mask,
`endif
    output logic [4:0] Ped_signal_time,
    output logic [1:0] Signal_pos,
    output logic       Light_out_time,
    output logic       Phase_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [4:0] GREEN_LD = 5'(GREEN_TIME);
    localparam logic [3:0] OUT_LD   = 4'(OUT_TIME);

    logic [1:0] state;
    logic [3:0] gap_cnt;

    // Next crossing to serve, from IDLE (candidate = current) or at gap end (candidate = current+1).
    logic       idle_ok;
    logic       out_ok;
    logic [1:0] idle_pos;
    logic [1:0] out_pos;

`ifdef PED_SKIP_EN
    // Cyclic search for the first unmasked crossing starting at cand; the msb flags that one exists.
    function automatic logic [2:0] next_free(input logic [1:0] cand, input logic [3:0] mask);
        logic [2:0] res;
        logic [1:0] p;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            p = cand + 2'(i);
            if (!mask[p]) res = {1'b1, p};
        end
        return res;
    endfunction

    assign {idle_ok, idle_pos} = next_free(Signal_pos, Skip_mask);
    assign {out_ok, out_pos}   = next_free(Signal_pos + 2'd1, Skip_mask);
`else
    assign idle_ok  = 1'b1;
    assign idle_pos = Signal_pos;
    assign out_ok   = 1'b1;
    assign out_pos  = Signal_pos + 2'd1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= ST_IDLE;
            gap_cnt         <= 4'd0;
            Ped_signal_time <= 5'd0;
            Signal_pos      <= 2'd0;
            Light_out_time  <= 1'b1;
            Phase_done      <= 1'b0;
        end else begin
            Phase_done <= 1'b0;
            if (Tick_1Hz) begin
                case (state)
                    ST_IDLE: begin
                        if (Enable && idle_ok) begin
                            state           <= ST_WALK;
                            Signal_pos      <= idle_pos;
                            Ped_signal_time <= GREEN_LD;
                            Light_out_time  <= 1'b0;
                        end
                    end
                    ST_WALK: begin
                        if (Ped_signal_time <= 5'd1) begin
                            state           <= ST_OUT;
                            Ped_signal_time <= 5'd0;
                            Light_out_time  <= 1'b1;
                            gap_cnt         <= OUT_LD;
                            Phase_done      <= 1'b1;
                        end else begin
                            Ped_signal_time <= Ped_signal_time - 5'd1;
                        end
                    end
                    ST_OUT: begin
                        if (gap_cnt > 4'd1) begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end else begin
                            // With every crossing masked the gap parks at 0 and retries each tick.
                            gap_cnt <= 4'd0;
                            if (out_ok) begin
                                Signal_pos <= out_pos;
                                if (Enable) begin
                                    state           <= ST_WALK;
                                    Ped_signal_time <= GREEN_LD;
                                    Light_out_time  <= 1'b0;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    default: begin
                        state          <= ST_IDLE;
                        Light_out_time <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_signal_sequencer.sv
// Directed bench for ped_signal_sequencer with default GREEN_TIME=20, OUT_TIME=2.
module tb_ped_signal_sequencer;

    logic       CLK;
    logic       RST;
    logic       Tick_1Hz;
    logic       Enable;
`ifdef PED_SKIP_EN
    logic [3:0] Skip_mask;
`endif
    logic [4:0] Ped_signal_time;
    logic [1:0] Signal_pos;
    logic       Light_out_time;
    logic       Phase_done;

    int n_checks;
    int n_fail;

    ped_signal_sequencer dut (
        .CLK             (CLK),
        .RST             (RST),
        .Tick_1Hz        (Tick_1Hz),
        .Enable          (Enable),
`ifdef PED_SKIP_EN
        .Skip_mask       (Skip_mask),
`endif
        .Ped_signal_time (Ped_signal_time),
        .Signal_pos      (Signal_pos),
        .Light_out_time  (Light_out_time),
        .Phase_done      (Phase_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One tick pulse followed by a sample point #1 after the edge that consumed it.
    task automatic tick();
        @(posedge CLK);
        #1 Tick_1Hz = 1'b1;
        @(posedge CLK);
        #1 Tick_1Hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (Ped_signal_time !== 5'd0) begin n_fail++; $display("FAIL reset_ped: got %0d expected 0", Ped_signal_time); end
        n_checks++;
        if (Signal_pos !== 2'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", Signal_pos); end
        n_checks++;
        if (Light_out_time !== 1'b1) begin n_fail++; $display("FAIL reset_lo: got %0b expected 1", Light_out_time); end
        n_checks++;
        if (Phase_done !== 1'b0) begin n_fail++; $display("FAIL reset_pd: got %0b expected 0", Phase_done); end
        RST = 1'b0;
        tick();
        n_checks++;
        if (Light_out_time !== 1'b1 || Ped_signal_time !== 5'd0) begin
            n_fail++; $display("FAIL idle_no_enable: lo=%0b ped=%0d expected lo=1 ped=0", Light_out_time, Ped_signal_time);
        end
    endtask

    task automatic test_start();
        Enable = 1'b1;
        tick();
        n_checks++;
        if (Ped_signal_time !== 5'd20 || Signal_pos !== 2'd0 || Light_out_time !== 1'b0) begin
            n_fail++; $display("FAIL start_walk: ped=%0d pos=%0d lo=%0b expected 20/0/0", Ped_signal_time, Signal_pos, Light_out_time);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (Ped_signal_time !== 5'd20) begin n_fail++; $display("FAIL hold_no_tick: got %0d expected 20", Ped_signal_time); end
        ticks(19);
        n_checks++;
        if (Ped_signal_time !== 5'd1 || Light_out_time !== 1'b0) begin
            n_fail++; $display("FAIL walk_last_sec: ped=%0d lo=%0b expected 1/0", Ped_signal_time, Light_out_time);
        end
        tick();
        n_checks++;
        if (Ped_signal_time !== 5'd0 || Light_out_time !== 1'b1 || Phase_done !== 1'b1) begin
            n_fail++; $display("FAIL walk_end: ped=%0d lo=%0b pd=%0b expected 0/1/1", Ped_signal_time, Light_out_time, Phase_done);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (Phase_done !== 1'b0) begin n_fail++; $display("FAIL pd_one_cycle: got %0b expected 0", Phase_done); end
    endtask

    task automatic test_rotation();
        tick();
        n_checks++;
        if (Light_out_time !== 1'b1 || Signal_pos !== 2'd0) begin
            n_fail++; $display("FAIL gap_first_tick: lo=%0b pos=%0d expected 1/0", Light_out_time, Signal_pos);
        end
        tick();
        n_checks++;
        if (Signal_pos !== 2'd1 || Ped_signal_time !== 5'd20 || Light_out_time !== 1'b0) begin
            n_fail++; $display("FAIL rotate_pos1: pos=%0d ped=%0d lo=%0b expected 1/20/0", Signal_pos, Ped_signal_time, Light_out_time);
        end
        for (int p = 2; p <= 4; p++) begin
            ticks(22);
            n_checks++;
            if (Signal_pos !== 2'(p) || Ped_signal_time !== 5'd20) begin
                n_fail++; $display("FAIL rotate_step%0d: pos=%0d ped=%0d expected %0d/20", p, Signal_pos, Ped_signal_time, p % 4);
            end
        end
    endtask

    task automatic test_stop();
        ticks(11);
        n_checks++;
        if (Ped_signal_time !== 5'd9 || Signal_pos !== 2'd0) begin
            n_fail++; $display("FAIL stop_pre: ped=%0d pos=%0d expected 9/0", Ped_signal_time, Signal_pos);
        end
        Enable = 1'b0;
        ticks(9);
        n_checks++;
        if (Ped_signal_time !== 5'd0 || Light_out_time !== 1'b1 || Phase_done !== 1'b1) begin
            n_fail++; $display("FAIL stop_walk_done: ped=%0d lo=%0b pd=%0b expected 0/1/1", Ped_signal_time, Light_out_time, Phase_done);
        end
        ticks(2);
        n_checks++;
        if (Signal_pos !== 2'd1 || Light_out_time !== 1'b1 || Ped_signal_time !== 5'd0) begin
            n_fail++; $display("FAIL stop_idle: pos=%0d lo=%0b ped=%0d expected 1/1/0", Signal_pos, Light_out_time, Ped_signal_time);
        end
        ticks(2);
        n_checks++;
        if (Signal_pos !== 2'd1 || Light_out_time !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold: pos=%0d lo=%0b expected 1/1", Signal_pos, Light_out_time);
        end
        Enable = 1'b1;
        tick();
        n_checks++;
        if (Signal_pos !== 2'd1 || Ped_signal_time !== 5'd20 || Light_out_time !== 1'b0) begin
            n_fail++; $display("FAIL restart: pos=%0d ped=%0d lo=%0b expected 1/20/0", Signal_pos, Ped_signal_time, Light_out_time);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK);
        #1 Tick_1Hz = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Tick_1Hz = 1'b0;
        n_checks++;
        if (Ped_signal_time !== 5'd17) begin n_fail++; $display("FAIL back_to_back: got %0d expected 17", Ped_signal_time); end
    endtask

    task automatic test_reset_mid_walk();
        ticks(17 + 2 + 13);
        n_checks++;
        if (Ped_signal_time !== 5'd7 || Signal_pos !== 2'd2) begin
            n_fail++; $display("FAIL pre_reset: ped=%0d pos=%0d expected 7/2", Ped_signal_time, Signal_pos);
        end
        RST = 1'b1;
        Tick_1Hz = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        Tick_1Hz = 1'b0;
        n_checks++;
        if (Ped_signal_time !== 5'd0 || Signal_pos !== 2'd0 || Light_out_time !== 1'b1 || Phase_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: ped=%0d pos=%0d lo=%0b pd=%0b expected 0/0/1/0",
                               Ped_signal_time, Signal_pos, Light_out_time, Phase_done);
        end
    endtask

`ifdef PED_SKIP_EN
    task automatic test_skip();
        Enable = 1'b1;
        Skip_mask = 4'b0000;
        ticks(1 + 20 + 1);
        Skip_mask = 4'b0110;
        tick();
        n_checks++;
        if (Signal_pos !== 2'd3 || Light_out_time !== 1'b0) begin
            n_fail++; $display("FAIL skip_0110: pos=%0d lo=%0b expected 3/0", Signal_pos, Light_out_time);
        end
        Skip_mask = 4'b1111;
        ticks(22);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (Light_out_time !== 1'b1 || Signal_pos !== 2'd3) begin
                n_fail++; $display("FAIL skip_all_%0d: lo=%0b pos=%0d expected 1/3", i, Light_out_time, Signal_pos);
            end
        end
        Skip_mask = 4'b0000;
        tick();
        n_checks++;
        if (Signal_pos !== 2'd0 || Light_out_time !== 1'b0 || Ped_signal_time !== 5'd20) begin
            n_fail++; $display("FAIL skip_clear: pos=%0d lo=%0b ped=%0d expected 0/0/20", Signal_pos, Light_out_time, Ped_signal_time);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        Tick_1Hz = 1'b0;
        Enable   = 1'b0;
`ifdef PED_SKIP_EN
        Skip_mask = 4'b0000;
`endif
        test_reset();
        test_start();
        test_rotation();
        test_stop();
        test_back_to_back();
        test_reset_mid_walk();
`ifdef PED_SKIP_EN
        test_skip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_signal_sequencer.md
# ped_signal_sequencer

Generates the pedestrian walk schedule for the four-crossing intersection. Rotates the active crossing, counts down the walk interval once per 1 Hz tick, and inserts a light-out gap between crossings. Its outputs, Ped_signal_time, Signal_pos and Light_out_time, are the inputs that the pedestrian LED driver uses to render solid, blinking and off states.

## Interface
- GREEN_TIME, 20: walk interval in seconds. Legal range is 14..31, so the LED driver sees a solid phase (>13) followed by 13 blink seconds.
- OUT_TIME, 2: light-out gap between crossings in seconds. Legal range is 1..15.
- CLK  input  1  system clock. Single clock domain.
- RST  input  1  reset, synchronous and active-high.
- Tick_1Hz  input  1  one-cycle enable pulse, once per second, synchronous to CLK.
- Enable  input  1  run request. Sampled only in IDLE and at the end of OUT.
- Skip_mask  input  4  bit n = skip crossing n. Present only with PED_SKIP_EN.
- Ped_signal_time  output  5  remaining walk seconds. 0 outside WALK.
- Signal_pos  output  2  active crossing, 0..3.
- Light_out_time  output  1  1 = all pedestrian LEDs dark (IDLE or OUT).
- Phase_done  output  1  one-cycle pulse at the end of a walk.

## Operation
- All outputs are registered. Reset values: Ped_signal_time=0, Signal_pos=0, Light_out_time=1, Phase_done=0, state=IDLE, gap counter=0.
- States:
  - IDLE: Light_out_time=1, Ped_signal_time=0, Signal_pos held.
  - WALK: Light_out_time=0.
  - OUT: Light_out_time=1, Ped_signal_time=0.
- IDLE → WALK: on Tick_1Hz with Enable=1. Loads Ped_signal_time=GREEN_TIME and keeps the current Signal_pos.
- WALK: each tick decrements Ped_signal_time. On the tick where the value is 1, the next state is OUT with Ped_signal_time=0, Light_out_time=1, gap counter=OUT_TIME, and Phase_done=1 for that single cycle.
- OUT: each tick decrements the gap counter. On the tick where it is 1:
  - Signal_pos advances by one, wrapping 3→0.
  - If Enable=1, go to WALK and load GREEN_TIME.
  - If Enable=0, go to IDLE. The advanced Signal_pos is held there.
- Enable is never sampled in WALK. A walk already in progress always completes, followed by its full gap.
- No tick, no change: every state holds all registers between ticks.
- Arithmetic: unsigned. Ped_signal_time never underflows below 0. The gap counter is 4 bits.
- RST has priority over Tick_1Hz and Enable in the same cycle.

## Timing
- Latency: outputs change on the CLK edge that samples Tick_1Hz=1. They are visible the cycle after the tick is presented.
- Back-to-back ticks on consecutive cycles are legal. Each one counts.
- Phase_done is high for exactly one CLK cycle. It coincides with the first cycle of Light_out_time=1 after a walk.
- Reset mid-operation: on the first RST edge every output takes its reset value, whatever the state or tick.
- Full cycle length per crossing is GREEN_TIME+OUT_TIME ticks. The default is 22 ticks.

## Configuration
- PED_SKIP_EN defined:
  - Skip_mask exists.
  - When leaving OUT (and when leaving IDLE), Signal_pos becomes the next crossing whose mask bit is 0, searched cyclically from the candidate position. In IDLE the candidate is the current position; at the end of OUT it is the current position plus 1.
  - If all four bits are 1, the block stays in its current light-out state (OUT holds with gap counter 0, or IDLE) with Light_out_time=1. It re-evaluates on every tick and keeps Signal_pos unchanged.
- PED_SKIP_EN undefined:
  - The Skip_mask port is absent.
  - Strict rotation 0→1→2→3→0.

## Test plan
- Reset: hold RST 2 cycles → Ped_signal_time=0, Signal_pos=0, Light_out_time=1, Phase_done=0.
- Start, defaults: Enable=1, first tick → WALK with Ped_signal_time=20, Signal_pos=0, Light_out_time=0. After 20 more ticks → Ped_signal_time=0, Light_out_time=1, one-cycle Phase_done.
- Rotation: continue with Enable=1. Two OUT ticks → Signal_pos=1, Ped_signal_time=20. After four complete phases, the walk following pos=3 shows Signal_pos=0.
- Stop: drop Enable when Ped_signal_time=9 at pos=0.
  - The walk counts down to 0, followed by 2 OUT ticks.
  - Then IDLE with Signal_pos=1, Light_out_time=1.
  - Re-raise Enable; the next tick gives WALK at pos=1 with Ped_signal_time=20.
- Reset mid-walk: assert RST at Ped_signal_time=7, pos=2, with Tick_1Hz high in the same cycle → next edge gives all reset values.
- PED_SKIP_EN:
  - Skip_mask=4'b0110 at the end of pos 0's gap → next WALK at Signal_pos=3.
  - Skip_mask=4'b1111 → Light_out_time stays 1 across 5 ticks.
  - Clear the mask → next tick enters WALK at the next crossing.
